// File: rtl/io_in_port.sv
// Input port controller: 4-phase req/ack capture into a small FIFO, read by the IN instruction.
// Optional two-flop request synchronizer enabled by defining IO_IN_SYNC_EN.

module io_in_port_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic             full,
  input logic             empty,
  input logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst) push |-> !full);
  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst) pop |-> !empty);
  a_count_in_range    : assert property (@(posedge clk) disable iff (!rst) count <= CNT_FULL);

endmodule

module io_in_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_req,
  input  logic [DATA_W-1:0]        ext_data,
  output logic                     ext_ack,
  input  logic                     re,
  output logic [DATA_W-1:0]        data_o,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                ack_r;
  logic                req_seen_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

`ifdef IO_IN_SYNC_EN
  logic req_s1_r;
  logic req_s2_r;

  // Two-flop synchronizer for the device request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_s1_r <= 1'b0;
      req_s2_r <= 1'b0;
    end else begin
      req_s1_r <= ext_req;
      req_s2_r <= req_s1_r;
    end
  end

  assign req_seen_s = req_s2_r;
`else
  assign req_seen_s = ext_req;
`endif

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // Handshake FSM: a word is captured only on the IDLE-to-ACK transition
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_seen_s && !full_s) begin
          state_nxt_s = ST_ACK;
          push_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!req_seen_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        push_s      = 1'b0;
      end
    endcase
  end

  // State register and registered acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= (state_nxt_s == ST_ACK);
    end
  end

  assign ext_ack = ack_r;

  // Pop only for a live read on a non-empty FIFO; a stalled read leaves state untouched
  assign pop_s     = re & ~empty_s & rst;
  assign stall_req = re & empty_s & rst;

  // Read path: head word while popping, zero otherwise
  always_comb begin
    data_o = {DATA_W{1'b0}};
    if (pop_s) begin
      data_o = mem_r[rd_ptr_r];
    end else begin
      data_o = {DATA_W{1'b0}};
    end
  end

  // FIFO storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ext_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop independently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count_o = count_r;

  io_in_port_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_r)
  );

endmodule
